// File: rtl/pwls_multichannel_alu.sv
// ---------------------------------------------------------------------------
// pwls_multichannel_alu
//
// Time-multiplexed ALU for the piecewise-linear synth voice bank. One channel
// is serviced per enabled cycle, round-robin. Servicing a channel does three
// things:
//   - advances its phase by a step derived from the channel period,
//   - applies the period/amp sweeps when the phase wraps,
//   - emits one PWL sample computed from the phase held before the update.
// Control and phase registers are loaded from the register-write bus
// independently of the ALU enable.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   en                   service channel ch this cycle
//   next_en              en-next-cycle hint (not needed by this implementation)
//   control_reg_write    permit for writes to idx 0-6
//   state_reg_write      permit for writes to idx 7 (phase)
//   reg_waddr            {ch[2:0], idx[2:0]}
//   reg_wdata            write data
//   reg_we               write strobe
//   tri_offset           global phase offset applied before the triangle fold
//   slope_exp            global right shift of the slope product
//   slope_offset         global offset added after the shift
//   sample, sample_ch    last computed sample and the channel it came from
//   sample_valid         high for one cycle after each en cycle
// ---------------------------------------------------------------------------
module pwls_multichannel_alu #(
    parameter int BITS            = 12,
    parameter int OCT_BITS        = 3,
    parameter int DETUNE_EXP_BITS = 3,
    parameter int SLOPE_EXP_BITS  = 4,
    parameter int NUM_CHANNELS    = 4,
    parameter int REG_BITS        = 16,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      next_en,
    input  logic                      control_reg_write,
    input  logic                      state_reg_write,
    input  logic [5:0]                reg_waddr,
    input  logic [REG_BITS-1:0]       reg_wdata,
    input  logic                      reg_we,
    input  logic [BITS-1:0]           tri_offset,
    input  logic [SLOPE_EXP_BITS-1:0] slope_exp,
    input  logic [BITS-4:0]           slope_offset,
    output logic [BITS-1:0]           sample,
    output logic [CW-1:0]             sample_ch,
    output logic                      sample_valid
);

    localparam int PER_W  = OCT_BITS + 10;           // {oct, mant[9:0]}
    localparam int AMP_W  = 6;
    localparam int PWM_W  = 8;
    localparam int SLP_W  = 8;
    localparam int SWP_W  = 16;
    // Step shifter: 11-bit mantissa left-shifted by up to 2^OCT_BITS-1,
    // padded so the [BITS+5:6] slice is always in range.
    localparam int SH_W   = 11 + (1 << OCT_BITS) + BITS;
    localparam int PROD_W = (BITS - 1) + SLP_W;      // tri * slope
    localparam int SCL_W  = BITS + AMP_W;            // y * amp

    // -----------------------------------------------------------------------
    // Per-channel storage
    // -----------------------------------------------------------------------
    logic [BITS-1:0]  phases      [NUM_CHANNELS];
    logic [PER_W-1:0] periods     [NUM_CHANNELS];
    logic [AMP_W-1:0] amps        [NUM_CHANNELS];
    logic [PWM_W-1:0] pwm_offsets [NUM_CHANNELS];
    logic [SLP_W-1:0] slopes0     [NUM_CHANNELS];
    logic [SLP_W-1:0] slopes1     [NUM_CHANNELS];
    logic [SWP_W-1:0] sweeps0     [NUM_CHANNELS];
    logic [SWP_W-1:0] sweeps1     [NUM_CHANNELS];

    logic [CW-1:0]    ch_q, ch_d;
    logic [BITS-1:0]  sample_q, sample_d;
    logic [CW-1:0]    sample_ch_q;
    logic             sample_valid_q;

    // -----------------------------------------------------------------------
    // Operand fetch for the channel being serviced
    // -----------------------------------------------------------------------
    logic [BITS-1:0]  cur_phase;
    logic [PER_W-1:0] cur_period;
    logic [AMP_W-1:0] cur_amp;
    logic [PWM_W-1:0] cur_pwm;
    logic [SLP_W-1:0] cur_slope0, cur_slope1;
    logic [SWP_W-1:0] cur_sweep0, cur_sweep1;

    always_comb begin
        cur_phase  = phases[ch_q];
        cur_period = periods[ch_q];
        cur_amp    = amps[ch_q];
        cur_pwm    = pwm_offsets[ch_q];
        cur_slope0 = slopes0[ch_q];
        cur_slope1 = slopes1[ch_q];
        cur_sweep0 = sweeps0[ch_q];
        cur_sweep1 = sweeps1[ch_q];
    end

    // -----------------------------------------------------------------------
    // Phase advance
    // -----------------------------------------------------------------------
    logic [OCT_BITS-1:0] oct;
    logic [9:0]          mant;
    logic [SH_W-1:0]     step_sh;
    logic [BITS-1:0]     step;
    logic [BITS-1:0]     phase_nxt;
    logic                wrap;

    always_comb begin
        oct  = cur_period[PER_W-1:10];
        mant = cur_period[9:0];
        // Implicit leading one on the mantissa, scaled by octave, then /64.
        step_sh = SH_W'({1'b1, mant}) << oct;
        step    = step_sh[BITS+5:6];
        {wrap, phase_nxt} = {1'b0, cur_phase} + {1'b0, step};
    end

    // -----------------------------------------------------------------------
    // Sweeps, applied only when the phase wraps
    // -----------------------------------------------------------------------
    // Two guard bits: the top one flags a negative result, the next one
    // flags overflow past the register range.
    logic [PER_W+1:0] per_sum;
    logic [PER_W-1:0] per_swept;
    logic [AMP_W+1:0] amp_sum;
    logic [AMP_W-1:0] amp_swept;

    always_comb begin
        per_sum = {2'b00, cur_period}
                + {{(PER_W + 2 - 8){cur_sweep0[7]}}, cur_sweep0[7:0]};
        if (per_sum[PER_W+1])
            per_swept = '0;
        else if (per_sum[PER_W])
            per_swept = '1;
        else
            per_swept = per_sum[PER_W-1:0];

        amp_sum = {2'b00, cur_amp}
                + {{(AMP_W + 2 - 4){cur_sweep1[3]}}, cur_sweep1[3:0]};
        if (amp_sum[AMP_W+1])
            amp_swept = '0;
        else if (amp_sum[AMP_W])
            amp_swept = '1;
        else
            amp_swept = amp_sum[AMP_W-1:0];
    end

    // -----------------------------------------------------------------------
    // PWL sample, computed from the phase before this cycle's advance
    // -----------------------------------------------------------------------
    logic [BITS-1:0]   q;
    logic [BITS-2:0]   tri_v;
    logic [SLP_W-1:0]  slope;
    logic [PROD_W-1:0] prod;
    logic [BITS-2:0]   prod_shr;
    logic [BITS:0]     y_sum;
    logic [BITS-1:0]   y;
    logic [SCL_W-1:0]  scaled;

    always_comb begin
        q     = cur_phase + tri_offset;
        // Fold the upper half back down to form a triangle.
        tri_v = q[BITS-1] ? ~q[BITS-2:0] : q[BITS-2:0];
        // Pulse-width split: the top 8 phase bits pick the active slope.
        slope = (cur_phase[BITS-1:BITS-8] < cur_pwm) ? cur_slope0 : cur_slope1;

        prod     = PROD_W'(tri_v) * PROD_W'(slope);
        prod_shr = prod[PROD_W-1:8] >> slope_exp;
        y_sum    = {2'b00, prod_shr} + {4'b0000, slope_offset};
        y        = y_sum[BITS] ? '1 : y_sum[BITS-1:0];

        scaled   = SCL_W'(y) * SCL_W'(cur_amp);
        sample_d = scaled[SCL_W-1:AMP_W];
    end

    // Round-robin channel pointer.
    always_comb begin
        if (ch_q == CW'(NUM_CHANNELS - 1))
            ch_d = '0;
        else
            ch_d = ch_q + CW'(1);
    end

    // -----------------------------------------------------------------------
    // Register-write decode
    // -----------------------------------------------------------------------
    logic [2:0] wr_ch;
    logic [2:0] wr_idx;

    assign wr_ch  = reg_waddr[5:3];
    assign wr_idx = reg_waddr[2:0];

    // -----------------------------------------------------------------------
    // State update. Within a channel the bus write is issued after the ALU
    // update so that a same-cycle write to the same register wins.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                phases[c]      <= '0;
                periods[c]     <= '0;
                amps[c]        <= '0;
                pwm_offsets[c] <= '0;
                slopes0[c]     <= '0;
                slopes1[c]     <= '0;
                sweeps0[c]     <= '0;
                sweeps1[c]     <= '0;
            end
            ch_q           <= '0;
            sample_q       <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= en;
            if (en) begin
                ch_q        <= ch_d;
                sample_q    <= sample_d;
                sample_ch_q <= ch_q;
            end

            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (en && ch_q == CW'(c)) begin
                    phases[c] <= phase_nxt;
                    if (wrap) begin
                        periods[c] <= per_swept;
                        amps[c]    <= amp_swept;
                    end
                end

                // Channel numbers beyond the bank never match and are dropped.
                if (reg_we && wr_ch == 3'(c)) begin
                    case (wr_idx)
                        3'd0: if (control_reg_write) periods[c]     <= reg_wdata[PER_W-1:0];
                        3'd1: if (control_reg_write) amps[c]        <= reg_wdata[AMP_W-1:0];
                        3'd2: if (control_reg_write) pwm_offsets[c] <= reg_wdata[PWM_W-1:0];
                        3'd3: if (control_reg_write) slopes0[c]     <= reg_wdata[SLP_W-1:0];
                        3'd4: if (control_reg_write) slopes1[c]     <= reg_wdata[SLP_W-1:0];
                        3'd5: if (control_reg_write) sweeps0[c]     <= reg_wdata[SWP_W-1:0];
                        3'd6: if (control_reg_write) sweeps1[c]     <= reg_wdata[SWP_W-1:0];
                        3'd7: if (state_reg_write)   phases[c]      <= reg_wdata[BITS-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;

    // Operands are fetched in the same cycle they are used, so the prefetch
    // hint, the detune exponent and the upper sweep bits carry no function.
    logic [DETUNE_EXP_BITS-1:0] unused_detune;
    logic                       unused_ok;

    assign unused_detune = '0;
    assign unused_ok     = ^{next_en, unused_detune, cur_sweep0[15:8], cur_sweep1[15:4]};

endmodule

// File: tb/tb_pwls_multichannel_alu.sv
module tb_pwls_multichannel_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, next_en, control_reg_write, state_reg_write, reg_we;
    logic [5:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic [11:0] tri_offset;
    logic [3:0]  slope_exp;
    logic [8:0]  slope_offset;
    logic [11:0] sample;
    logic [1:0]  sample_ch;
    logic        sample_valid;

    always #5 clk = ~clk;

    pwls_multichannel_alu dut (
        .clk(clk), .reset(reset), .en(en), .next_en(next_en),
        .control_reg_write(control_reg_write), .state_reg_write(state_reg_write),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .tri_offset(tri_offset), .slope_exp(slope_exp), .slope_offset(slope_offset),
        .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int m_phase[4], m_period[4], m_amp[4], m_pwm[4], m_s0[4], m_s1[4], m_sw0[4], m_sw1[4];
    int tb_ch;

    typedef struct { int ch; int smp; } exp_t;
    exp_t sb[$];
    exp_t mx;
    bit   ovr;
    int   ovr_val;

    function automatic int sext(input int v, input int b);
        return (v >= (1 << (b - 1))) ? v - (1 << b) : v;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int model_sample(input int c);
        int p, q, tri_v, s, y;
        p     = m_phase[c];
        q     = (p + int'(tri_offset)) % 4096;
        tri_v = (q >= 2048) ? 4095 - q : q;
        s     = ((p / 16) < m_pwm[c]) ? m_s0[c] : m_s1[c];
        y     = ((tri_v * s) / 256) / (1 << slope_exp) + int'(slope_offset);
        if (y > 4095) y = 4095;
        return (y * m_amp[c]) / 64;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0; m_period[i] = 0; m_amp[i] = 0; m_pwm[i] = 0;
            m_s0[i] = 0; m_s1[i] = 0; m_sw0[i] = 0; m_sw1[i] = 0;
        end
        tb_ch = 0;
        sb.delete();
        ovr = 0;
    endtask

    // One clock of stimulus; the model applies the ALU step then the write.
    task automatic cycle(input bit e, input bit we, input int wch, input int widx,
                         input int wdata, input bit cp, input bit sp);
        exp_t x;
        int st, ns;
        @(negedge clk);
        en = e; reg_we = we;
        reg_waddr = 6'((wch << 3) | widx);
        reg_wdata = 16'(wdata);
        control_reg_write = cp; state_reg_write = sp;
        if (e) begin
            x.ch  = tb_ch;
            x.smp = ovr ? ovr_val : model_sample(tb_ch);
            ovr   = 0;
            sb.push_back(x);
            st = (((1024 + (m_period[tb_ch] & 1023)) << (m_period[tb_ch] >> 10)) >> 6) & 4095;
            ns = m_phase[tb_ch] + st;
            if (ns >= 4096) begin
                m_period[tb_ch] = clamp(m_period[tb_ch] + sext(m_sw0[tb_ch] & 255, 8), 0, 8191);
                m_amp[tb_ch]    = clamp(m_amp[tb_ch] + sext(m_sw1[tb_ch] & 15, 4), 0, 63);
            end
            m_phase[tb_ch] = ns & 4095;
            tb_ch = (tb_ch + 1) % 4;
        end
        if (we && wch < 4) begin
            case (widx)
                0: if (cp) m_period[wch] = wdata & 8191;
                1: if (cp) m_amp[wch]    = wdata & 63;
                2: if (cp) m_pwm[wch]    = wdata & 255;
                3: if (cp) m_s0[wch]     = wdata & 255;
                4: if (cp) m_s1[wch]     = wdata & 255;
                5: if (cp) m_sw0[wch]    = wdata & 65535;
                6: if (cp) m_sw1[wch]    = wdata & 65535;
                7: if (sp) m_phase[wch]  = wdata & 4095;
                default: ;
            endcase
        end
    endtask

    task automatic idle();                           cycle(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic step();                           cycle(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int c, input int i, input int d); cycle(0, 1, c, i, d, 1, 1); endtask

    // Reset, optionally with a permitted phase write pending in the same cycle.
    task automatic do_reset(input bit with_write);
        @(negedge clk);
        reset = 1; en = 0;
        reg_we = with_write; reg_waddr = {3'd1, 3'd7}; reg_wdata = 16'h0777;
        control_reg_write = 1; state_reg_write = 1;
        @(negedge clk);
        reg_we = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    // Scoreboard: every sample_valid pops the oldest expected sample.
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mx = sb.pop_front();
                check("sample_ch", int'(sample_ch), mx.ch);
                check("sample", int'(sample), mx.smp);
            end
        end
    end

    // ---------------- sample vectors on channel 0 ----------------
    typedef struct {
        int phase, amp, pwm, s0, s1, sexp, soff, toff, exp_smp;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int old;
        int ch_save;

        //             phase  amp pwm  s0   s1  sexp soff toff   exp
        vecs[0] = '{12'h7FF, 63,   0, 255, 255,  0,   0,     0, 2007};
        vecs[1] = '{12'h7FF,  0,   0, 255, 255,  0,   0,     0,    0};
        vecs[2] = '{12'h800, 32,   0, 255, 255,  0,   0,     0, 1019};
        vecs[3] = '{12'h100, 63, 32, 128,   0,  1,  10,     0,   72};
        vecs[4] = '{12'h100, 63, 16, 128,   0,  1,  10,     0,    9};
        vecs[5] = '{12'h000, 63,   1, 255,   0,  2,   0, 12'hC00, 250};
        vecs[6] = '{12'h7FF, 63,   0, 255, 255,  0, 511,     0, 2510};
        vecs[7] = '{12'h7FF, 63,   0, 255, 255, 15, 100,     0,   98};

        reset = 1; en = 0; next_en = 0; reg_we = 0; reg_waddr = 0; reg_wdata = 0;
        control_reg_write = 0; state_reg_write = 0;
        tri_offset = 0; slope_exp = 0; slope_offset = 0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset wins over a same-cycle write.
        do_reset(1);
        check("rst_sample", int'(sample), 0);
        check("rst_sample_ch", int'(sample_ch), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_ch", int'(dut.ch_q), 0);
        check("rst_phase1_write_dropped", int'(dut.phases[1]), 0);

        // Period 0 -> step 16; channels visited 0,1,2,3 then back to 0.
        repeat (4) step();
        idle();
        check("phase0_after_round", int'(dut.phases[0]), 16);
        check("ch_wrapped", int'(dut.ch_q), 0);
        step();
        idle();
        check("phase0_second_visit", int'(dut.phases[0]), 32);

        // Octave 7 -> step 2048.
        do_reset(0);
        wr(0, 0, 16'h1C00);
        repeat (4) step();
        idle();
        check("phase0_oct7_v1", int'(dut.phases[0]), 2048);
        repeat (4) step();
        idle();
        check("phase0_oct7_v2", int'(dut.phases[0]), 0);
        check("period0_no_sweep", int'(dut.periods[0]), 16'h1C00);

        // Sweeps on wrap: period 5-1=4, amp 60+7 saturates to 63.
        wr(0, 5, 16'h00FF);
        wr(0, 6, 16'h0007);
        wr(0, 1, 60);
        wr(0, 0, 5);
        wr(0, 7, 12'hFF0);
        step();
        idle();
        check("period0_swept", int'(dut.periods[0]), 4);
        check("amp0_sat_hi", int'(dut.amps[0]), 63);
        check("phase0_wrapped", int'(dut.phases[0]), 0);
        wr(0, 0, 0);
        wr(0, 7, 12'hFF0);
        repeat (3) step();
        step();
        idle();
        check("period0_sat_lo", int'(dut.periods[0]), 0);

        // Write permits.
        old = m_phase[1];
        cycle(0, 1, 1, 7, 12'h123, 1, 0);
        idle();
        check("phase1_no_permit", int'(dut.phases[1]), old);
        cycle(0, 1, 1, 7, 12'h123, 0, 1);
        idle();
        check("phase1_permit", int'(dut.phases[1]), 12'h123);
        cycle(0, 1, 1, 1, 33, 0, 1);
        idle();
        check("amp1_no_permit", int'(dut.amps[1]), 0);
        cycle(0, 1, 5, 1, 33, 1, 1);
        idle();
        check("amp1_bad_ch_ignored", int'(dut.amps[1]), 0);

        // en low: state held, no valid, writes still land.
        ch_save = tb_ch;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) wr(2, 1, 17);
            else idle();
            check("idle_valid", int'(sample_valid), 0);
        end
        idle();
        check("idle_ch_held", int'(dut.ch_q), ch_save);
        check("idle_write_lands", int'(dut.amps[2]), 17);
        for (int i = 0; i < 4; i++)
            check("idle_phase_held", int'(dut.phases[i]), m_phase[i]);

        // Bus write beats the ALU phase update in the same cycle.
        while (tb_ch != 0) step();
        cycle(1, 1, 0, 7, 12'h055, 1, 1);
        idle();
        check("write_beats_alu", int'(dut.phases[0]), 12'h055);

        // Sample vectors.
        do_reset(0);
        for (int v = 0; v < 8; v++) begin
            tri_offset   = 12'(vecs[v].toff);
            slope_exp    = 4'(vecs[v].sexp);
            slope_offset = 9'(vecs[v].soff);
            wr(0, 7, vecs[v].phase);
            wr(0, 1, vecs[v].amp);
            wr(0, 2, vecs[v].pwm);
            wr(0, 3, vecs[v].s0);
            wr(0, 4, vecs[v].s1);
            while (tb_ch != 0) step();
            ovr = 1;
            ovr_val = vecs[v].exp_smp;
            step();
            idle();
        end

        idle();
        idle();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
